// File: rtl/kuznechik_decipher_if.sv
// Handshake and data bundle of the Kuznechik block decryptor.
// The slave side is the decryptor; the master side is its requester/consumer.
interface kuznechik_decipher_if;
    logic         request_i;
    logic         ack_i;
    logic [127:0] data_i;
    logic         busy_o;
    logic         valid_o;
    logic [127:0] data_o;
    logic [2:0]   state_dbg;

    // request_i starts a block only while idle (or in FINISH together with ack_i);
    // valid_o/data_o hold the result until ack_i is seen in FINISH.
    modport master (
        output request_i, ack_i, data_i,
        input  busy_o, valid_o, data_o, state_dbg
    );

    modport slave (
        input  request_i, ack_i, data_i,
        output busy_o, valid_o, data_o, state_dbg
    );
endinterface

// File: rtl/kuznechik_decipher.sv
// Iterative GOST R 34.12-2015 (Kuznechik) block decryptor: one byte-serial
// inverse-L step per clock, ten fixed round keys, request/busy/valid/ack handshake.
module kuznechik_decipher (
    input  logic                       clk_i,
    input  logic                       resetn_i,
    kuznechik_decipher_if.slave        bus
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_KEY    = 3'd1,
        ST_LINV   = 3'd2,
        ST_SINV   = 3'd3,
        ST_FINISH = 3'd4
    } state_e;

    // Forward Pi permutation; the inverse is derived from it so only one table exists.
    localparam logic [7:0] PI [256] = '{
        8'd252, 8'd238, 8'd221, 8'd17,  8'd207, 8'd110, 8'd49,  8'd22,  8'd251, 8'd196, 8'd250, 8'd218, 8'd35,  8'd197, 8'd4,   8'd77,
        8'd233, 8'd119, 8'd240, 8'd219, 8'd147, 8'd46,  8'd153, 8'd186, 8'd23,  8'd54,  8'd241, 8'd187, 8'd20,  8'd205, 8'd95,  8'd193,
        8'd249, 8'd24,  8'd101, 8'd90,  8'd226, 8'd92,  8'd239, 8'd33,  8'd129, 8'd28,  8'd60,  8'd66,  8'd139, 8'd1,   8'd142, 8'd79,
        8'd5,   8'd132, 8'd2,   8'd174, 8'd227, 8'd106, 8'd143, 8'd160, 8'd6,   8'd11,  8'd237, 8'd152, 8'd127, 8'd212, 8'd211, 8'd31,
        8'd235, 8'd52,  8'd44,  8'd81,  8'd234, 8'd200, 8'd72,  8'd171, 8'd242, 8'd42,  8'd104, 8'd162, 8'd253, 8'd58,  8'd206, 8'd204,
        8'd181, 8'd112, 8'd14,  8'd86,  8'd8,   8'd12,  8'd118, 8'd18,  8'd191, 8'd114, 8'd19,  8'd71,  8'd156, 8'd183, 8'd93,  8'd135,
        8'd21,  8'd161, 8'd150, 8'd41,  8'd16,  8'd123, 8'd154, 8'd199, 8'd243, 8'd145, 8'd120, 8'd111, 8'd157, 8'd158, 8'd178, 8'd177,
        8'd50,  8'd117, 8'd25,  8'd61,  8'd255, 8'd53,  8'd138, 8'd126, 8'd109, 8'd84,  8'd198, 8'd128, 8'd195, 8'd189, 8'd13,  8'd87,
        8'd223, 8'd245, 8'd36,  8'd169, 8'd62,  8'd168, 8'd67,  8'd201, 8'd215, 8'd121, 8'd214, 8'd246, 8'd124, 8'd34,  8'd185, 8'd3,
        8'd224, 8'd15,  8'd236, 8'd222, 8'd122, 8'd148, 8'd176, 8'd188, 8'd220, 8'd232, 8'd40,  8'd80,  8'd78,  8'd51,  8'd10,  8'd74,
        8'd167, 8'd151, 8'd96,  8'd115, 8'd30,  8'd0,   8'd98,  8'd68,  8'd26,  8'd184, 8'd56,  8'd130, 8'd100, 8'd159, 8'd38,  8'd65,
        8'd173, 8'd69,  8'd70,  8'd146, 8'd39,  8'd94,  8'd85,  8'd47,  8'd140, 8'd163, 8'd165, 8'd125, 8'd105, 8'd213, 8'd149, 8'd59,
        8'd7,   8'd88,  8'd179, 8'd64,  8'd134, 8'd172, 8'd29,  8'd247, 8'd48,  8'd55,  8'd107, 8'd228, 8'd136, 8'd217, 8'd231, 8'd137,
        8'd225, 8'd27,  8'd131, 8'd73,  8'd76,  8'd63,  8'd248, 8'd254, 8'd141, 8'd83,  8'd170, 8'd144, 8'd202, 8'd216, 8'd133, 8'd97,
        8'd32,  8'd113, 8'd103, 8'd164, 8'd45,  8'd43,  8'd9,   8'd91,  8'd203, 8'd155, 8'd37,  8'd208, 8'd190, 8'd229, 8'd108, 8'd82,
        8'd89,  8'd166, 8'd116, 8'd210, 8'd230, 8'd244, 8'd180, 8'd192, 8'd209, 8'd102, 8'd175, 8'd194, 8'd57,  8'd75,  8'd99,  8'd182
    };

    // Round-key ROM: the keys.mem image, i.e. the expansion of
    // 8899aabbccddeeff0011223344556677fedcba98765432100123456789abcdef.
    function automatic logic [127:0] round_key(input logic [3:0] idx);
        logic [127:0] k;
        case (idx)
            4'd0:    k = 128'h8899aabbccddeeff0011223344556677;
            4'd1:    k = 128'hfedcba98765432100123456789abcdef;
            4'd2:    k = 128'hdb31485315694343228d6aef8cc78c44;
            4'd3:    k = 128'h3d4553d8e9cfec6815ebadc40a9ffd04;
            4'd4:    k = 128'h57646468c44a5e28d3e59246f429f1ac;
            4'd5:    k = 128'hbd079435165c6432b532e82834da581b;
            4'd6:    k = 128'h51e640757e8745de705727265a0098b1;
            4'd7:    k = 128'h5a7925017b9fdd3ed72a91a22286f984;
            4'd8:    k = 128'hbb44e25378c73123a5f32f73cdb6e517;
            4'd9:    k = 128'h72e9dd7416bcf45b755dbaa88e4a4043;
            default: k = '0;
        endcase
        return k;
    endfunction

    // GF(2^8) product modulo x^8+x^7+x^6+x+1.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = x[7] ? ({x[6:0], 1'b0} ^ 8'hc3) : {x[6:0], 1'b0};
        end
        return p;
    endfunction

    function automatic logic [7:0] sbox_inv(input logic [7:0] v);
        logic [7:0] r;
        r = '0;
        for (int i = 0; i < 256; i++) begin
            if (PI[i[7:0]] == v) r = i[7:0];
        end
        return r;
    endfunction

    state_e       state_q, state_d;
    logic [127:0] work_q, work_d;
    logic [3:0]   round_cnt_q, round_cnt_d;
    logic [3:0]   l_phase_cnt_q, l_phase_cnt_d;
    logic         valid_q, valid_d;
    logic [127:0] data_q, data_d;

    logic [127:0] key_mix;
    logic [7:0]   linv_byte;
    logic [127:0] sinv_word;

    function automatic logic [7:0] wb(input logic [127:0] w, input int k);
        return w[8*k +: 8];
    endfunction

    always_comb begin
        key_mix = work_q ^ round_key(round_cnt_q);

        // One R^-1 step: the byte shifted out at the top re-enters as the new byte 0.
        linv_byte = gf_mul(wb(work_q, 14), 8'd148) ^ gf_mul(wb(work_q, 13), 8'd32)
                  ^ gf_mul(wb(work_q, 12), 8'd133) ^ gf_mul(wb(work_q, 11), 8'd16)
                  ^ gf_mul(wb(work_q, 10), 8'd194) ^ gf_mul(wb(work_q, 9), 8'd192)
                  ^ wb(work_q, 8)                  ^ gf_mul(wb(work_q, 7), 8'd251)
                  ^ wb(work_q, 6)                  ^ gf_mul(wb(work_q, 5), 8'd192)
                  ^ gf_mul(wb(work_q, 4), 8'd194)  ^ gf_mul(wb(work_q, 3), 8'd16)
                  ^ gf_mul(wb(work_q, 2), 8'd133)  ^ gf_mul(wb(work_q, 1), 8'd32)
                  ^ gf_mul(wb(work_q, 0), 8'd148)  ^ wb(work_q, 15);

        sinv_word = '0;
        for (int k = 0; k < 16; k++) begin
            sinv_word[8*k +: 8] = sbox_inv(work_q[8*k +: 8]);
        end
    end

    always_comb begin
        state_d       = state_q;
        work_d        = work_q;
        round_cnt_d   = round_cnt_q;
        l_phase_cnt_d = l_phase_cnt_q;
        valid_d       = valid_q;
        data_d        = data_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.request_i) begin
                    work_d      = bus.data_i;
                    round_cnt_d = 4'd9;
                    state_d     = ST_KEY;
                end
            end
            ST_KEY: begin
                work_d = key_mix;
                if (round_cnt_q == 4'd0) begin
                    data_d  = key_mix;
                    valid_d = 1'b1;
                    state_d = ST_FINISH;
                end else begin
                    round_cnt_d   = round_cnt_q - 4'd1;
                    l_phase_cnt_d = 4'd0;
                    state_d       = ST_LINV;
                end
            end
            ST_LINV: begin
                work_d = {work_q[119:0], linv_byte};
                if (l_phase_cnt_q == 4'd15) begin
                    state_d = ST_SINV;
                end else begin
                    l_phase_cnt_d = l_phase_cnt_q + 4'd1;
                end
            end
            ST_SINV: begin
                work_d  = sinv_word;
                state_d = ST_KEY;
            end
            ST_FINISH: begin
                // data_o is left alone here so the old result stays visible during a back-to-back run.
                if (bus.ack_i) begin
                    valid_d = 1'b0;
                    if (bus.request_i) begin
                        work_d      = bus.data_i;
                        round_cnt_d = 4'd9;
                        state_d     = ST_KEY;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            state_q       <= ST_IDLE;
            work_q        <= '0;
            round_cnt_q   <= '0;
            l_phase_cnt_q <= '0;
            valid_q       <= 1'b0;
            data_q        <= '0;
        end else begin
            state_q       <= state_d;
            work_q        <= work_d;
            round_cnt_q   <= round_cnt_d;
            l_phase_cnt_q <= l_phase_cnt_d;
            valid_q       <= valid_d;
            data_q        <= data_d;
        end
    end

    assign bus.busy_o    = (state_q != ST_IDLE);
    assign bus.valid_o   = valid_q;
    assign bus.data_o    = data_q;
    assign bus.state_dbg = state_q;

endmodule

// File: tb/tb_kuznechik_decipher.sv
// Directed bench for kuznechik_decipher using the GOST R 34.12/34.13 Kuznechik
// test key and its published ECB ciphertext/plaintext pairs.
module tb_kuznechik_decipher;

    localparam logic [127:0] C1 = 128'h7f679d90bebc24305a468d42b9d4edcd;
    localparam logic [127:0] P1 = 128'h1122334455667700ffeeddccbbaa9988;
    localparam logic [127:0] C2 = 128'hb429912c6e0032f9285452d76718d08b;
    localparam logic [127:0] P2 = 128'h00112233445566778899aabbcceeff0a;
    localparam logic [127:0] C3 = 128'hf0ca33549d247ceef3f5a5313bd4b157;
    localparam logic [127:0] P3 = 128'h112233445566778899aabbcceeff0a00;
    localparam logic [127:0] C4 = 128'hd0b09ccde830b9eb3a02c4c5aa8ada98;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LINV   = 3'd2;
    localparam logic [2:0] S_FINISH = 3'd4;

    logic clk;
    logic resetn;
    int   tests_run;
    int   tests_failed;
    logic [127:0] exp_q[$];
    logic [127:0] expected;

    kuznechik_decipher_if bus ();

    kuznechik_decipher dut (
        .clk_i    (clk),
        .resetn_i (resetn),
        .bus      (bus)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog expired");
    end

    // Driver tasks
    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [127:0] ct);
        bus.request_i = 1'b1;
        bus.data_i    = ct;
        step();
        bus.request_i = 1'b0;
        bus.data_i    = rand128();
    endtask

    task automatic wait_valid(output int cycles);
        cycles = 0;
        while (bus.valid_o !== 1'b1 && cycles < 400) begin
            step();
            cycles++;
        end
    endtask

    task automatic do_ack();
        bus.ack_i = 1'b1;
        step();
        bus.ack_i = 1'b0;
    endtask

    // Scenarios
    task automatic test_reset();
        resetn = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.request_i = 1'($urandom_range(0, 1));
            bus.ack_i     = 1'($urandom_range(0, 1));
            bus.data_i    = rand128();
            step();
        end
        tests_run++;
        if ({bus.busy_o, bus.valid_o, bus.data_o} !== 130'd0) begin
            tests_failed++;
            $display("FAIL reset_outputs: busy=%b valid=%b data=%h, expected 0 0 0",
                     bus.busy_o, bus.valid_o, bus.data_o);
        end
        tests_run++;
        if (bus.state_dbg !== S_IDLE) begin
            tests_failed++;
            $display("FAIL reset_state: got %0d expected %0d", bus.state_dbg, S_IDLE);
        end
        bus.request_i = 1'b0;
        bus.ack_i     = 1'b0;
        resetn        = 1'b1;
        for (int i = 0; i < 10; i++) begin
            bus.data_i = rand128();
            step();
            tests_run++;
            if ({bus.busy_o, bus.valid_o, bus.data_o} !== 130'd0) begin
                tests_failed++;
                $display("FAIL idle_hold cycle %0d: busy=%b valid=%b data=%h, expected 0 0 0",
                         i, bus.busy_o, bus.valid_o, bus.data_o);
            end
        end
    endtask

    task automatic test_standard_vector();
        int n;
        send(C1);
        exp_q.push_back(P1);
        tests_run++;
        if (bus.busy_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL std_busy_after_accept: got %b expected 1", bus.busy_o);
        end
        wait_valid(n);
        tests_run++;
        if (n != 163) begin
            tests_failed++;
            $display("FAIL std_latency: got %0d expected 163", n);
        end
        expected = exp_q.pop_front();
        tests_run++;
        if (bus.data_o !== expected) begin
            tests_failed++;
            $display("FAIL std_plaintext: got %h expected %h", bus.data_o, expected);
        end
        tests_run++;
        if (bus.state_dbg !== S_FINISH || bus.busy_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL std_finish_state: state=%0d busy=%b expected %0d 1",
                     bus.state_dbg, bus.busy_o, S_FINISH);
        end
        do_ack();
        tests_run++;
        if ({bus.valid_o, bus.busy_o, bus.data_o} !== {1'b0, 1'b0, P1}) begin
            tests_failed++;
            $display("FAIL std_after_ack: valid=%b busy=%b data=%h expected 0 0 %h",
                     bus.valid_o, bus.busy_o, bus.data_o, P1);
        end
    endtask

    task automatic test_request_ignored();
        int n;
        send(C3);
        exp_q.push_back(P3);
        for (int i = 0; i < 5; i++) step();
        tests_run++;
        if (bus.state_dbg !== S_LINV) begin
            tests_failed++;
            $display("FAIL ign_in_linv: state=%0d expected %0d", bus.state_dbg, S_LINV);
        end
        bus.request_i = 1'b1;
        bus.ack_i     = 1'b1;
        bus.data_i    = C4;
        step();
        bus.request_i = 1'b0;
        bus.ack_i     = 1'b0;
        bus.data_i    = rand128();
        tests_run++;
        if (bus.busy_o !== 1'b1 || bus.valid_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL ign_still_busy: busy=%b valid=%b expected 1 0", bus.busy_o, bus.valid_o);
        end
        wait_valid(n);
        tests_run++;
        if (n != 157) begin
            tests_failed++;
            $display("FAIL ign_latency: got %0d expected 157", n);
        end
        expected = exp_q.pop_front();
        tests_run++;
        if (bus.data_o !== expected) begin
            tests_failed++;
            $display("FAIL ign_plaintext: got %h expected %h", bus.data_o, expected);
        end
    endtask

    task automatic test_hold_ack();
        int bad;
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            bus.ack_i     = 1'b0;
            bus.request_i = 1'($urandom_range(0, 1));
            bus.data_i    = rand128();
            step();
            tests_run++;
            if ({bus.valid_o, bus.data_o} !== {1'b1, P3}) begin
                tests_failed++;
                $display("FAIL hold_stable cycle %0d: valid=%b data=%h expected 1 %h",
                         i, bus.valid_o, bus.data_o, P3);
            end
        end
        bus.request_i = 1'b0;
        do_ack();
        tests_run++;
        if (bus.valid_o !== 1'b0 || bus.busy_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL hold_release: valid=%b busy=%b expected 0 0", bus.valid_o, bus.busy_o);
        end
    endtask

    task automatic test_back_to_back();
        int n;
        int bad;
        send(C1);
        exp_q.push_back(P1);
        wait_valid(n);
        tests_run++;
        if (n != 163) begin
            tests_failed++;
            $display("FAIL b2b_first_latency: got %0d expected 163", n);
        end
        expected = exp_q.pop_front();
        tests_run++;
        if (bus.data_o !== expected) begin
            tests_failed++;
            $display("FAIL b2b_first_plaintext: got %h expected %h", bus.data_o, expected);
        end
        bus.ack_i     = 1'b1;
        bus.request_i = 1'b1;
        bus.data_i    = C2;
        exp_q.push_back(P2);
        step();
        bus.ack_i     = 1'b0;
        bus.request_i = 1'b0;
        bus.data_i    = rand128();
        tests_run++;
        if ({bus.valid_o, bus.busy_o, bus.data_o} !== {1'b0, 1'b1, P1}) begin
            tests_failed++;
            $display("FAIL b2b_restart: valid=%b busy=%b data=%h expected 0 1 %h",
                     bus.valid_o, bus.busy_o, bus.data_o, P1);
        end
        n   = 0;
        bad = 0;
        while (bus.valid_o !== 1'b1 && n < 400) begin
            step();
            n++;
            if (bus.valid_o !== 1'b1 && bus.data_o !== P1) bad++;
        end
        tests_run++;
        if (n != 163) begin
            tests_failed++;
            $display("FAIL b2b_second_latency: got %0d expected 163", n);
        end
        tests_run++;
        if (bad != 0) begin
            tests_failed++;
            $display("FAIL b2b_old_result_held: %0d cycles changed, expected 0", bad);
        end
        expected = exp_q.pop_front();
        tests_run++;
        if (bus.data_o !== expected) begin
            tests_failed++;
            $display("FAIL b2b_second_plaintext: got %h expected %h", bus.data_o, expected);
        end
        do_ack();
        tests_run++;
        if (bus.busy_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL b2b_idle: busy=%b expected 0", bus.busy_o);
        end
    endtask

    task automatic test_reset_mid_op();
        int n;
        send(C1);
        // After 80 more edges the block sits in the round-4 inverse-L pass, phase 7.
        for (int i = 0; i < 80; i++) step();
        tests_run++;
        if (bus.state_dbg !== S_LINV) begin
            tests_failed++;
            $display("FAIL midrst_pre_state: got %0d expected %0d", bus.state_dbg, S_LINV);
        end
        resetn = 1'b0;
        #1;
        tests_run++;
        if ({bus.busy_o, bus.valid_o, bus.data_o, bus.state_dbg} !== 133'd0) begin
            tests_failed++;
            $display("FAIL midrst_outputs: busy=%b valid=%b data=%h state=%0d expected all 0",
                     bus.busy_o, bus.valid_o, bus.data_o, bus.state_dbg);
        end
        for (int i = 0; i < 3; i++) step();
        resetn = 1'b1;
        step();
        tests_run++;
        if (bus.valid_o !== 1'b0 || bus.busy_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL midrst_no_pulse: valid=%b busy=%b expected 0 0", bus.valid_o, bus.busy_o);
        end
        send(C1);
        exp_q.push_back(P1);
        wait_valid(n);
        tests_run++;
        if (n != 163) begin
            tests_failed++;
            $display("FAIL midrst_latency: got %0d expected 163", n);
        end
        expected = exp_q.pop_front();
        tests_run++;
        if (bus.data_o !== expected) begin
            tests_failed++;
            $display("FAIL midrst_plaintext: got %h expected %h", bus.data_o, expected);
        end
        do_ack();
    endtask

    // Sequence and final report
    initial begin
        tests_run     = 0;
        tests_failed  = 0;
        resetn        = 1'b0;
        bus.request_i = 1'b0;
        bus.ack_i     = 1'b0;
        bus.data_i    = '0;

        test_reset();
        test_standard_vector();
        test_request_ignored();
        test_hold_ack();
        test_back_to_back();
        test_reset_mid_op();

        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
